frame_max_finder: RTL and testbench
===================================

// Module: frame_max_finder
// PURPOSE
//  Streaming reduction stage that finds the maximum value, and its index, over a frame of samples.
//  It drives a comparator instance (input1 = incoming sample, input2 = running max) and consumes
//  that comparator's 'greater' flag, so the comparator sits between this block's cmp_* ports.
//  The result is handed downstream through a valid/ready handshake. Typical use: per-frame peak detection.
// PARAMETERS
//  DATA_W     8   sample width; also the comparator input_size
//  FRAME_LEN  8   samples per frame when in_last is not asserted earlier (>=2)
//  IDX_W      3   index/count width; must satisfy 2**IDX_W >= FRAME_LEN
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  in_valid     in   1        sample present on in_data
//  in_ready     out  1        block accepts a sample this cycle (accept = in_valid & in_ready)
//  in_data      in   DATA_W   sample
//  in_last      in   1        sample closes the frame early; qualified by accept
//  cmp_a        out  DATA_W   to comparator input1; always equals in_data (combinational)
//  cmp_b        out  DATA_W   to comparator input2; always equals max_r
//  cmp_greater  in   1        from comparator 'greater'; combinational, same cycle
//  out_valid    out  1        frame result is valid
//  out_ready    in   1        downstream takes the result (xfer = out_valid & out_ready)
//  out_max      out  DATA_W   maximum sample of the frame
//  out_idx      out  IDX_W    index (0-based) of the first occurrence of the maximum
//  out_count    out  IDX_W+1  number of samples in the frame (1..FRAME_LEN)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, max_r=0, idx_r=0, cnt_r=0; in_ready=1 (derived from the
//   state once rst is released), out_valid=0, out_max=0, out_idx=0, out_count=0.
//  States:
//   IDLE   waits for the first sample of a frame. in_ready=1. cmp_greater is ignored.
//          On accept: max_r=in_data, idx_r=0, cnt_r=1.
//          If in_last, or FRAME_LEN==1 is reached, finish the frame (see DONE load); else go to ACC.
//   ACC    in_ready=1. On accept:
//          - if cmp_greater: max_r=in_data, idx_r=cnt_r;
//          - cnt_r+=1;
//          - if in_last or cnt_r+1==FRAME_LEN, finish the frame.
//          Ties (comparator equal) do not replace max_r, so the earliest index wins.
//   DONE   in_ready=0, out_valid=1; outputs are held stable until xfer.
//          On xfer go to IDLE; the next sample is accepted at the earliest on the cycle after xfer
//          (no same-cycle bypass).
//  DONE load, in the accept cycle that finishes the frame:
//   - out_max and out_idx take the post-update max and index, i.e. the final sample is included
//     in the reduction;
//   - out_count takes the post-increment count;
//   - out_valid rises on the next clock edge.
//   Latency from the last accepted sample to out_valid: 1 cycle.
//  Outputs are registered; out_* change only on the DONE load or on reset.
//  in_last in IDLE produces a 1-sample frame: out_idx=0, out_count=1.
//  The count never exceeds FRAME_LEN; in_last on the FRAME_LEN-th sample is redundant and harmless.
//  in_valid while in DONE: not accepted, and the sample must be held by the sender (standard handshake).
//  out_ready while out_valid=0: ignored.
//  Reset mid-frame or while in DONE discards the partial or pending result; there is no output pulse.
//  Unsigned compare semantics, as provided by the comparator.
// TESTING
//  1 Reset: assert rst mid-cycle -> out_valid=0, in_ready=1, out_max=0 immediately; no output until a new frame.
//  2 Full frame 3,9,2,9,7,1,0,5 (FRAME_LEN=8), out_ready=1 -> one cycle after the 8th accept:
//    out_max=9, out_idx=1, out_count=8.
//  3 Early end: 4,6 with in_last on 6 -> out_max=6, out_idx=1, out_count=2;
//    in_last on the first sample 0xFF -> out_max=255, out_idx=0, out_count=1.
//  4 Backpressure: hold out_ready=0 for 5 cycles after a frame completes, with in_valid=1
//    -> in_ready=0 and out_* stable throughout; after xfer, the held sample starts the next frame
//    as idx 0 one cycle later.
//  5 All-equal frame of 8x 0x10 -> out_max=0x10, out_idx=0. Descending 7..0 -> out_max=7, out_idx=0.
//    Ascending 0..7 -> out_max=7, out_idx=7.
//  6 Reset asserted after 4 accepts of a frame -> no out_valid; a new frame of 1,2,3,4,5,6,7,8
//    reports out_max=8, out_idx=7, out_count=8.

Source files
------------

// File: rtl/frame_max_finder.sv
`default_nettype none
// ============================================================================
// Module      : frame_max_finder
// Description : Streaming per-frame maximum/index reduction driving an
//               external comparator, with a valid/ready result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_max_finder #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic [DATA_W-1:0] o_cmp_a,
  output logic [DATA_W-1:0] o_cmp_b,
  input  logic              i_cmp_greater,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_max,
  output logic [IDX_W-1:0]  o_out_idx,
  output logic [IDX_W:0]    o_out_count
);

  localparam logic [IDX_W:0] c_FRAME_LEN = (IDX_W+1)'(FRAME_LEN);
  localparam logic [IDX_W:0] c_ONE       = (IDX_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] w_max_nx;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nx;
  logic [IDX_W:0]    r_cnt;
  logic [IDX_W:0]    w_cnt_nx;
  logic [IDX_W:0]    w_cnt_inc;
  logic              w_accept;
  logic              w_finish;

  logic [DATA_W-1:0] r_out_max;
  logic [IDX_W-1:0]  r_out_idx;
  logic [IDX_W:0]    r_out_count;

  assign o_cmp_a     = i_in_data;
  assign o_cmp_b     = r_max;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_cnt_inc   = r_cnt + c_ONE;
  assign o_out_max   = r_out_max;
  assign o_out_idx   = r_out_idx;
  assign o_out_count = r_out_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_max   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_max   <= w_max_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_max_nx    = r_max;
    w_idx_nx    = r_idx;
    w_cnt_nx    = r_cnt;
    w_finish    = 1'b0;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The comparator result is meaningless here: the first sample always seeds the max.
        o_in_ready = 1'b1;
        if (w_accept) begin
          w_max_nx = i_in_data;
          w_idx_nx = '0;
          w_cnt_nx = c_ONE;
          if (i_in_last || (c_FRAME_LEN == c_ONE)) begin
            w_finish = 1'b1;
          end else begin
            w_state_nx = S_ACC;
          end
        end
      end
      S_ACC: begin
        o_in_ready = 1'b1;
        if (w_accept) begin
          // Strictly greater only, so ties keep the earliest index.
          if (i_cmp_greater) begin
            w_max_nx = i_in_data;
            w_idx_nx = r_cnt[IDX_W-1:0];
          end
          w_cnt_nx = w_cnt_inc;
          if (i_in_last || (w_cnt_inc == c_FRAME_LEN)) begin
            w_finish = 1'b1;
          end
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    if (w_finish) begin
      w_state_nx = S_DONE;
    end
  end

  // Result registers capture the post-update values so the closing sample is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_max   <= '0;
      r_out_idx   <= '0;
      r_out_count <= '0;
    end else if (w_finish) begin
      r_out_max   <= w_max_nx;
      r_out_idx   <= w_idx_nx;
      r_out_count <= w_cnt_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_max_finder.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_max_finder
// Description : Randomised self-checking bench for frame_max_finder with a
//               behavioural frame reduction model and a comparator model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_max_finder;

  logic       clk;
  logic       rst;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_in_data;
  logic       i_in_last;
  logic [7:0] o_cmp_a;
  logic [7:0] o_cmp_b;
  logic       i_cmp_greater;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [7:0] o_out_max;
  logic [2:0] o_out_idx;
  logic [3:0] o_out_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  frame_max_finder #(.DATA_W(8), .FRAME_LEN(8), .IDX_W(3)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_data    (i_in_data),
    .i_in_last    (i_in_last),
    .o_cmp_a      (o_cmp_a),
    .o_cmp_b      (o_cmp_b),
    .i_cmp_greater(i_cmp_greater),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_max    (o_out_max),
    .o_out_idx    (o_out_idx),
    .o_out_count  (o_out_count)
  );

  // Unsigned comparator placed between the cmp ports.
  assign i_cmp_greater = (o_cmp_a > o_cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends the samples in q as one frame, then checks and retires the result.
  task automatic run_frame(input bit last_on_full, input int gap_max, input int hold);
    int n;
    int t;
    int exp_max;
    int exp_idx;
    int pre_max;
    n = q.size();
    exp_max = -1;
    exp_idx = 0;
    foreach (q[k]) begin
      if (int'(q[k]) > exp_max) begin
        exp_max = int'(q[k]);
        exp_idx = k;
      end
    end
    pre_max = -1;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        i_in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      i_in_valid = 1'b1;
      i_in_data  = q[i];
      i_in_last  = (i == n - 1) && ((n < 8) || last_on_full);
      t = 0;
      while (!o_in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (!o_in_ready) begin
        errors++;
        $display("FAIL frame_in_ready_timeout: in_ready=%0b required 1", o_in_ready);
      end
      checks++;
      if (o_cmp_a !== q[i]) begin
        errors++;
        $display("FAIL cmp_a: got %0h required %0h", o_cmp_a, q[i]);
      end
      if (i > 0) begin
        checks++;
        if (int'(o_cmp_b) !== pre_max) begin
          errors++;
          $display("FAIL cmp_b running max at sample %0d: got %0h required %0h", i, o_cmp_b, pre_max);
        end
      end
      if (int'(q[i]) > pre_max) pre_max = int'(q[i]);
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL result_valid cycle %0d: out_valid=%0b in_ready=%0b required 1/0", h, o_out_valid, o_in_ready);
      end
      checks++;
      if (int'(o_out_max) !== exp_max || int'(o_out_idx) !== exp_idx || int'(o_out_count) !== n) begin
        errors++;
        $display("FAIL result_value: max=%0h idx=%0d cnt=%0d required max=%0h idx=%0d cnt=%0d",
                 o_out_max, o_out_idx, o_out_count, exp_max, exp_idx, n);
      end
      if (h < hold) @(negedge clk);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_xfer: out_valid=%0b in_ready=%0b required 0/1", o_out_valid, o_in_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_out_max !== 8'h00 ||
        o_out_idx !== 3'd0 || o_out_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: v=%0b rdy=%0b max=%0h idx=%0d cnt=%0d required 0 1 0 0 0",
               o_out_valid, o_in_ready, o_out_max, o_out_idx, o_out_count);
    end
    i_in_valid = 1'b1;
    i_in_data  = 8'h5A;
    i_in_last  = 1'b1;
    @(negedge clk);
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_out_max !== 8'h5A) begin
      errors++;
      $display("FAIL pending_before_reset: v=%0b max=%0h required 1 5a", o_out_valid, o_out_max);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_out_max !== 8'h00 || o_out_count !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: v=%0b rdy=%0b max=%0h cnt=%0d required 0 1 0 0",
               o_out_valid, o_in_ready, o_out_max, o_out_count);
    end
    @(negedge clk);
    rst = 1'b0;
    i_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_output_after_reset: out_valid=%0b required 0", o_out_valid);
      end
    end
    i_out_ready = 1'b0;
  endtask

  task automatic test_full_frame();
    q = '{8'd3, 8'd9, 8'd2, 8'd9, 8'd7, 8'd1, 8'd0, 8'd5};
    run_frame(1'b0, 0, 0);
  endtask

  task automatic test_early_end();
    q = '{8'd4, 8'd6};
    run_frame(1'b0, 0, 0);
    q = '{8'hFF};
    run_frame(1'b0, 0, 1);
  endtask

  task automatic test_backpressure();
    q = '{8'd11, 8'd40, 8'd22};
    run_frame(1'b0, 0, 0);
    q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd30, 8'd6, 8'd7, 8'd8};
    // Manual variant: keep the result pending while a new sample waits.
    foreach (q[k]) begin
      i_in_valid = 1'b1;
      i_in_data  = q[k];
      @(negedge clk);
    end
    i_in_data = 8'hAB;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_max !== 8'd30 ||
          o_out_idx !== 3'd4 || o_out_count !== 4'd8) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: rdy=%0b v=%0b max=%0h idx=%0d cnt=%0d required 0 1 1e 4 8",
                 c, o_in_ready, o_out_valid, o_out_max, o_out_idx, o_out_count);
      end
      @(negedge clk);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_xfer: v=%0b rdy=%0b required 0 1", o_out_valid, o_in_ready);
    end
    @(negedge clk);
    i_in_data = 8'h05;
    i_in_last = 1'b1;
    checks++;
    if (o_cmp_b !== 8'hAB) begin
      errors++;
      $display("FAIL held_sample_start: cmp_b=%0h required ab", o_cmp_b);
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_out_max !== 8'hAB || o_out_idx !== 3'd0 || o_out_count !== 4'd2) begin
      errors++;
      $display("FAIL held_sample_frame: v=%0b max=%0h idx=%0d cnt=%0d required 1 ab 0 2",
               o_out_valid, o_out_max, o_out_idx, o_out_count);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
  endtask

  task automatic test_patterns();
    q = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    run_frame(1'b0, 0, 0);
    q = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    run_frame(1'b1, 0, 0);
    q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    run_frame(1'b0, 1, 0);
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 4; k++) begin
      i_in_valid = 1'b1;
      i_in_data  = 8'(8'hF0 + k);
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midframe_reset_no_output: out_valid=%0b required 0", o_out_valid);
      end
      @(negedge clk);
    end
    q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run_frame(1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int len;
      bit narrow;
      len = $urandom_range(1, 8);
      narrow = ($urandom_range(0, 1) == 1);
      q = {};
      for (int k = 0; k < len; k++) begin
        q.push_back(narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255)));
      end
      run_frame($urandom_range(0, 1) == 1, 2, $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst         = 1'b1;
    i_in_valid  = 1'b0;
    i_in_data   = 8'h00;
    i_in_last   = 1'b0;
    i_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_early_end();
    test_backpressure();
    test_patterns();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
